mod_pow: RTL and testbench
==========================

Name: mod_pow

Overview:
- Sequential modular exponentiator: computes result = base^exp mod MOD.
- Sits directly upstream of `mont_redc`, which is its only multiplier: it instantiates one `mont_redc` (same WIDTH/MOD/NPRIME) and time-shares it, one multiply per cycle.
- Right-to-left binary square-and-multiply with fixed, data-independent latency by default.
- Used by NTT twiddle generation and modular inversion (exp = MOD-2).

Parameters:
- WIDTH, 32, operand/result width; passed to `mont_redc`.
- MOD, 998244353, prime modulus; passed to `mont_redc`.
- NPRIME, 998244351, Montgomery constant; passed to `mont_redc`.
- EXP_WIDTH, 32, exponent width; number of exponent bits processed.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- base  input  WIDTH  base; any value, including values >= MOD.
- exp  input  EXP_WIDTH  exponent, unsigned.
- busy  output  1  high in PREP, MUL, SQR and DONE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  base^exp mod MOD; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0; internal acc, b, e and bit counter cleared. Reset mid-operation aborts; no done pulse follows.
- Registered state: acc (WIDTH), b (WIDTH), e (EXP_WIDTH, shifted right each bit), cnt (bit counter, clog2(EXP_WIDTH+1) bits).
- Multiplier mux: `mont_redc` inputs are (b_in,1) in PREP, (acc,b) in MUL, (b,b) in SQR; the output is always < MOD.
- IDLE:
  - start=1 on edge E0: latch base and exp into b and e; acc<=1; cnt<=0; go to PREP.
  - start=0: stay in IDLE.
- PREP (1 cycle): b <= b*1 mod MOD (full reduction of base); go to MUL.
- MUL: if e[0]=1 then acc <= acc*b mod MOD, else acc is held; go to SQR.
- SQR: b <= b*b mod MOD; e <= e>>1; cnt <= cnt+1. Go to DONE if cnt == EXP_WIDTH-1, else go to MUL.
  - The final squaring is executed even though unused (constant time).
- DONE (1 cycle): result <= acc; done=1; go to IDLE.
- Latency: done is high in the cycle following edge E0 + 2*EXP_WIDTH + 1, i.e. 2*EXP_WIDTH+2 cycles after acceptance (66 for EXP_WIDTH=32).
- Back-to-back: start may be reasserted in the IDLE cycle immediately after DONE.
- start while busy=1: ignored; base and exp changes while busy are ignored (inputs are latched at E0).
- exp=0: result=1, including base=0 (0^0 = 1 convention).
- base ≡ 0 (mod MOD) with exp>0: result=0.
- result only changes in DONE or on reset; done is never high for more than one cycle.

Optional Feature:
- Macro: MOD_POW_EARLY_EXIT_EN.
- Defined:
  - On entry to MUL, if e==0, skip straight to DONE (non-constant time).
  - Latency = 2*(index of highest set bit of exp + 1) + 2 cycles; exp=0 gives 2 cycles (PREP, DONE).
  - Results are identical to the non-early-exit build.
- Undefined: fixed latency 2*EXP_WIDTH+2 for every exp; e==0 has no effect on the state sequence.

Test Plan:
- base=2, exp=10 -> result=1024; done exactly 66 cycles after the start edge; busy high for 66 cycles.
- base=3, exp=MOD-2 -> result=332748118; then base=3, exp=MOD-1 -> result=1, with start reasserted in the first IDLE cycle after done.
- exp=0 for base=0 and base=123456 -> result=1; base=MOD, exp=5 -> result=0; base=MOD-1, exp=3 -> result=MOD-1.
- Start base=5, exp=7 (expect 78125); pulse start with base=9 while busy -> ignored, result=78125, exactly one done pulse.
- Assert rst_n=0 at cycle 20 of a run -> busy, done and result are 0 immediately; no done pulse; a fresh start afterwards completes normally.
- With MOD_POW_EARLY_EXIT_EN: base=2, exp=10 -> result=1024 with latency 10; exp=0 -> latency 2. Without the macro, both take 66 cycles.

Source files
------------

// File: rtl/mod_pow.sv
// ============================================================================
// Module   : mod_pow (with its multiplier mont_redc)
// Brief    : Sequential modular exponentiator, right-to-left square-and-multiply.
//            Optional build macro MOD_POW_EARLY_EXIT_EN ends the loop once the
//            remaining exponent is zero (non-constant time).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_redc #(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] MOD    = 998244353,
    parameter logic [WIDTH-1:0] NPRIME = 998244351
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    // R^2 mod MOD with R = 2^WIDTH; lets two REDC passes return a plain a*b mod MOD.
    function automatic logic [WIDTH-1:0] calc_r2();
        logic [WIDTH:0] r;
        r = (WIDTH+1)'(1);
        for (int i = 0; i < 2*WIDTH; i++) begin
            r = r << 1;
            if (r >= {1'b0, MOD}) r = r - {1'b0, MOD};
        end
        return WIDTH'(r);
    endfunction

    localparam logic [WIDTH-1:0] R2 = calc_r2();

    // Valid for t < MOD*R; output is fully reduced.
    function automatic logic [WIDTH-1:0] redc(input logic [2*WIDTH-1:0] t);
        logic [WIDTH-1:0]   m;
        logic [2*WIDTH:0]   s;
        logic [WIDTH:0]     u;
        m = WIDTH'(t) * NPRIME;
        s = {1'b0, t} + ((2*WIDTH+1)'(m) * (2*WIDTH+1)'(MOD));
        u = (WIDTH+1)'(s >> WIDTH);
        if (u >= {1'b0, MOD}) u = u - {1'b0, MOD};
        return WIDTH'(u);
    endfunction

    logic [WIDTH-1:0] mont_ab;

    always_comb begin
        mont_ab = redc({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});
        y       = redc({{WIDTH{1'b0}}, mont_ab} * {{WIDTH{1'b0}}, R2});
    end
endmodule

module mod_pow #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] MOD       = 998244353,
    parameter logic [WIDTH-1:0] NPRIME    = 998244351,
    parameter int unsigned      EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);
    localparam int unsigned      CNT_W = $clog2(EXP_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_MUL  = 3'd2,
        S_SQR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     acc, b, mul_a, mul_b, prod;
    logic [EXP_WIDTH-1:0] e;
    logic [CNT_W-1:0]     cnt;

    mont_redc #(
        .WIDTH  (WIDTH),
        .MOD    (MOD),
        .NPRIME (NPRIME)
    ) u_mont_redc (
        .a (mul_a),
        .b (mul_b),
        .y (prod)
    );

    always_comb begin
        mul_a = acc;
        mul_b = b;
        case (state)
            S_PREP: begin mul_a = b; mul_b = WIDTH'(1); end
            S_SQR:  begin mul_a = b; mul_b = b;         end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_PREP;
`ifdef MOD_POW_EARLY_EXIT_EN
            S_PREP: state_next = (e == '0) ? S_DONE : S_MUL;
            S_SQR:  state_next = (cnt == LAST || (e >> 1) == '0) ? S_DONE : S_MUL;
`else
            S_PREP: state_next = S_MUL;
            S_SQR:  state_next = (cnt == LAST) ? S_DONE : S_MUL;
`endif
            S_MUL:  state_next = S_SQR;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            b      <= '0;
            e      <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    b   <= base;
                    e   <= exp;
                    acc <= WIDTH'(1);
                    cnt <= '0;
                end
                S_PREP: b <= prod;
                S_MUL:  if (e[0]) acc <= prod;
                S_SQR: begin
                    b   <= prod;
                    e   <= e >> 1;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
            // acc is final on every path into DONE, so result is valid alongside done.
            if (state != S_DONE && state_next == S_DONE) result <= acc;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
endmodule

`default_nettype wire

// File: tb/tb_mod_pow.sv
// ============================================================================
// Module   : tb_mod_pow
// Brief    : Directed self-checking bench for mod_pow (honours MOD_POW_EARLY_EXIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_pow;
    localparam int unsigned EXP_WIDTH = 32;
    localparam logic [31:0] MOD       = 32'd998244353;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base;
    logic [31:0] exp;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    mod_pow #(
        .WIDTH     (32),
        .MOD       (MOD),
        .NPRIME    (32'd998244351),
        .EXP_WIDTH (EXP_WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .base   (base),
        .exp    (exp),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    function automatic int exp_latency(input logic [31:0] x);
`ifdef MOD_POW_EARLY_EXIT_EN
        int hb = -1;
        for (int i = 0; i < 32; i++) if (x[i]) hb = i;
        return 2 * (hb + 1) + 2;
`else
        return 2 * EXP_WIDTH + 2;
`endif
    endfunction

    // inject >= 0 pulses start with other operands while the run is busy.
    task automatic run(input string tag, input logic [31:0] b_v, input logic [31:0] e_v,
                       input logic [31:0] want, input int inject);
        int cyc    = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        base  = b_v;
        exp   = e_v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (busy) busy_n++;
        while (!seen && cyc < 200) begin
            if (cyc == inject) begin
                start = 1'b1;
                base  = 32'd9;
                exp   = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                check({tag, "_result"}, result, want);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, cyc + 1, exp_latency(e_v));
        check({tag, "_busy_cycles"}, busy_n, exp_latency(e_v));
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_result_held"}, result, want);
    endtask

    initial begin
        bit seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        exp   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("pow2_10", 32'd2, 32'd10, 32'd1024, -1);
        run("inv3", 32'd3, MOD - 32'd2, 32'd332748118, -1);
        run("fermat3", 32'd3, MOD - 32'd1, 32'd1, -1);
        run("zero_pow_zero", 32'd0, 32'd0, 32'd1, -1);
        run("b123456_e0", 32'd123456, 32'd0, 32'd1, -1);
        run("mod_e5", MOD, 32'd5, 32'd0, -1);
        run("modm1_e3", MOD - 32'd1, 32'd3, MOD - 32'd1, -1);
        run("maxbase_e1", 32'hFFFF_FFFF, 32'd1, 32'd301989883, -1);
        run("ignore_start", 32'd5, 32'd7, 32'd78125, 10);

        // Abort mid-run with an asynchronous reset.
        base  = 32'd2;
        exp   = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        seen_done = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 if (done) seen_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 if (done) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        run("after_reset", 32'd2, 32'd10, 32'd1024, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
